// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command-side initiator for the registered 16-bit ALU (ALU_16B). Commands
// are buffered in a small FIFO. Each command is driven onto the ALU
// operand/function inputs and held while the ALU's clocked latency runs out.
// The ALU result and flags are then captured and returned over a response
// handshake, so upstream logic never has to time the ALU itself.
//
// Handshake semantics (both CMD_* and RSP_*): a transfer happens on a rising
// CLK edge where VALID and READY are both high. A producer that raises VALID
// keeps it and its payload stable until that transfer. READY may depend
// combinationally only on local state, never on the partner's VALID.
//
// Parameters
//   DEPTH   : command FIFO entries (power of two, >= 2)
//   ALU_LAT : clock edges from ALU operand sampling to valid ALU_OUT/flags (>= 1)
//
// Optional feature macro: ALU_SEQ_CHECK_EN
//   defined   : captured flags are checked against the flag class expected
//               for the issued function; any mismatch sets sticky ERR.
//   undefined : no check logic, ERR tied low.
//
// Ports
//   CLK, RST                 : clock (rising edge), async active-low reset
//   CMD_VALID/CMD_READY      : command handshake (READY = FIFO not full)
//   CMD_A, CMD_B, CMD_FUN    : command payload
//   A, B, ALU_FUN            : drive the ALU inputs (ALU_FUN = 4'b1111 is NOP)
//   ALU_OUT, *_Flag          : ALU result and flags
//   RSP_VALID/RSP_READY      : response handshake
//   RSP_DATA, RSP_FLAGS      : captured result, {Shift,CMP,Logic,Arith,Carry}
//   ERR                      : sticky flag-class mismatch
//   o_dbg_state              : current FSM state (IDLE=0, ISSUE=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  input  logic [3:0]  CMD_FUN,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] ALU_OUT,
  input  logic        Carry_Flag,
  input  logic        Arith_Flag,
  input  logic        Logic_Flag,
  input  logic        CMP_Flag,
  input  logic        Shift_Flag,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic [4:0]  RSP_FLAGS,
  output logic        ERR,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [3:0] FUN_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [35:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [35:0]   w_head;

  // Full/empty come from the registered count only, so a command pushed at
  // an edge cannot be popped before the following edge (no bypass).
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign CMD_READY = ~w_full;
  assign w_push    = CMD_VALID & ~w_full;
  assign w_head    = r_mem[r_rd_ptr];

  // Storage carries no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {CMD_FUN, CMD_B, CMD_A};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue/response FSM
  // ---------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_capture;
  logic          w_rsp_done;
  logic          w_cnt_dec;
  logic [LW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_cnt != '0) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          w_rsp_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------
  // Operand registers and latency counter
  // ---------------------------------------------------------------------
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_fun;

  // A/B keep their last issued values; only the function returns to NOP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_fun <= FUN_NOP;
      r_cnt <= '0;
    end else if (w_pop) begin
      r_a   <= w_head[15:0];
      r_b   <= w_head[31:16];
      r_fun <= w_head[35:32];
      r_cnt <= LW'(ALU_LAT);
    end else begin
      if (w_capture) r_fun <= FUN_NOP;
      if (w_cnt_dec) r_cnt <= r_cnt - LW'(1);
    end
  end

  assign A       = r_a;
  assign B       = r_b;
  assign ALU_FUN = r_fun;

  // ---------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic [4:0]  r_rsp_flags;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= ALU_OUT;
      r_rsp_flags <= {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag};
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_FLAGS = r_rsp_flags;

  // ---------------------------------------------------------------------
  // Optional flag-class check
  // ---------------------------------------------------------------------
`ifdef ALU_SEQ_CHECK_EN
  logic [3:0] w_exp_class;   // {Shift, CMP, Logic, Arith}; Carry is not checked
  logic       w_mismatch;
  logic       r_err;

  // r_fun still holds the issued function at the capture edge.
  always_comb begin
    w_exp_class = 4'b0000;
    if (r_fun <= 4'd3)       w_exp_class = 4'b0001;
    else if (r_fun <= 4'd9)  w_exp_class = 4'b0010;
    else if (r_fun <= 4'd12) w_exp_class = 4'b0100;
    else if (r_fun <= 4'd14) w_exp_class = 4'b1000;
    else                     w_exp_class = 4'b0000;
  end

  assign w_mismatch = ({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} != w_exp_class);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                         r_err <= 1'b0;
    else if (w_capture && w_mismatch) r_err <= 1'b1;
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

endmodule
